// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding, default width and operand magnitude helper for mul_seq_param
package mul_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [31:0] abs_op(input logic [31:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

endpackage

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: handshake FSM and iteration counter driving the mul_seq_param datapath
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_early,
    output logic o_ready,
    output logic o_busy,
    output logic o_done,
    output logic o_load,
    output logic o_step,
    output logic o_finish
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == IDLE) ? (i_start ? RUN : IDLE) :
                 (r_state == RUN)  ? (o_finish ? DONE : RUN) : IDLE;
    end

    always_comb begin
        o_ready  = r_state == IDLE;
        o_busy   = r_state != IDLE;
        o_done   = r_state == DONE;
        o_load   = o_ready & i_start;
        o_step   = r_state == RUN;
        o_finish = o_step & ((r_cnt == CNT_W'(WIDTH - 1)) | i_early);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_cnt <= '0;
        else if (o_load) r_cnt <= '0;
        else if (o_step) r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/mul_seq_param.sv
// mul_seq_param: sequential shift-add multiplier, signed/unsigned, start/ready/done; MUL_EARLY_TERM_EN ends RUN once the multiplier is exhausted
module mul_seq_param
    import mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_sign;
    logic [2*WIDTH-1:0] r_product;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic               w_early;
    logic               w_load;
    logic               w_step;
    logic               w_finish;

    assign w_abs_a   = WIDTH'(abs_op(32'(a), signed_mode & a[WIDTH-1]));
    assign w_abs_b   = WIDTH'(abs_op(32'(b), signed_mode & b[WIDTH-1]));
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
`ifdef MUL_EARLY_TERM_EN
    assign w_early   = (r_mplier >> 1) == '0;
`else
    assign w_early   = 1'b0;
`endif
    assign product   = r_product;

    mul_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .i_start  (start),
        .i_early  (w_early),
        .o_ready  (ready),
        .o_busy   (busy),
        .o_done   (done),
        .o_load   (w_load),
        .o_step   (w_step),
        .o_finish (w_finish)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_sign   <= 1'b0;
        end else if (w_load) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
            r_mplier <= w_abs_b;
            r_acc    <= '0;
            r_sign   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (w_step) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_product <= '0;
        else if (w_finish) r_product <= r_sign ? -w_acc_nxt : w_acc_nxt;
    end

endmodule
